// File: rtl/perf_counter_unit_pkg.sv
// rtl/perf_counter_unit_pkg.sv - default sizes and counter index constants for the perf counter unit
package perf_pkg;

    localparam int NUM_CNT = 4;
    localparam int CNT_W   = 16;
    localparam int SEL_W   = (NUM_CNT > 1) ? $clog2(NUM_CNT) : 1;

    // Which pipeline event each counter is wired to.
    localparam int CNT_CYCLE   = 0;
    localparam int CNT_INSTR   = 1;
    localparam int CNT_STALL   = 2;
    localparam int CNT_BRTAKEN = 3;

endpackage

// File: rtl/perf_counter_unit_if.sv
// rtl/perf_counter_unit_if.sv - pipeline-side bus of the perf counter unit
// Signals:
//   evt       per-counter event strobes
//   rd_en     capture strobe from ID
//   rd_sel    counter index to capture
//   perf_cnt  captured counter value (to ALU)
//   cfg_we    enable-mask write strobe
//   cfg_en    enable mask loaded on cfg_we
//   clr       per-counter clear strobes
//   perf_ovf  sticky per-counter overflow flags
// Modports: master = pipeline, slave = perf_counter_unit.
interface perf_counter_unit_if
    import perf_pkg::*;
#(
    parameter int N_CNT = NUM_CNT,
    parameter int C_W   = CNT_W,
    parameter int S_W   = SEL_W
);

    logic [N_CNT-1:0] evt;
    logic             rd_en;
    logic [S_W-1:0]   rd_sel;
    logic [C_W-1:0]   perf_cnt;
    logic             cfg_we;
    logic [N_CNT-1:0] cfg_en;
    logic [N_CNT-1:0] clr;
    logic [N_CNT-1:0] perf_ovf;

    modport master (
        output evt, rd_en, rd_sel, cfg_we, cfg_en, clr,
        input  perf_cnt, perf_ovf
    );

    modport slave (
        input  evt, rd_en, rd_sel, cfg_we, cfg_en, clr,
        output perf_cnt, perf_ovf
    );

endinterface

// File: rtl/perf_counter_unit_slice.sv
// rtl/perf_counter_unit_slice.sv - one event counter with sticky overflow flag
// Ports: clk, rst_n (sync active-low), clr (clear counter and ovf),
//        inc (count one event), cnt (counter value), ovf (sticky overflow).
// Build option: PERF_CNT_SAT_EN defined -> counter saturates at max instead of wrapping.
module perf_counter_slice #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output logic             ovf
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
            ovf <= 1'b0;
        end else if (clr) begin
            cnt <= '0;
            ovf <= 1'b0;
        end else if (inc) begin
            if (cnt == {CNT_W{1'b1}}) begin
                ovf <= 1'b1;
`ifdef PERF_CNT_SAT_EN
                cnt <= cnt;
`else
                cnt <= '0;
`endif
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/perf_counter_unit.sv
// rtl/perf_counter_unit.sv - hardware performance counters feeding the ALU perf_cnt operand
// Ports: clk, rst_n (sync active-low), bus (perf_counter_unit_if.slave: evt, rd_en,
//        rd_sel, perf_cnt, cfg_we, cfg_en, clr, perf_ovf).
// Build option: PERF_CNT_SAT_EN (handled in perf_counter_slice) selects saturate vs wrap.
module perf_counter_unit
    import perf_pkg::*;
#(
    parameter int NUM_CNT = perf_pkg::NUM_CNT,
    parameter int CNT_W   = perf_pkg::CNT_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    perf_counter_unit_if.slave    bus
);

    localparam int SW = (NUM_CNT > 1) ? $clog2(NUM_CNT) : 1;

    logic [NUM_CNT-1:0] en_q;
    logic [NUM_CNT-1:0] ovf_vec;
    logic [CNT_W-1:0]   cnt_arr [NUM_CNT];
    logic [CNT_W-1:0]   perf_cnt_q;
    logic [SW-1:0]      sel;

    assign sel = bus.rd_sel;

    // Enable mask; events on the cfg_we edge still see the old mask.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            en_q <= '1;
        end else if (bus.cfg_we) begin
            en_q <= bus.cfg_en;
        end
    end

    for (genvar i = 0; i < NUM_CNT; i++) begin : g_slice
        perf_counter_slice #(
            .CNT_W (CNT_W)
        ) u_slice (
            .clk   (clk),
            .rst_n (rst_n),
            .clr   (bus.clr[i]),
            .inc   (en_q[i] & bus.evt[i]),
            .cnt   (cnt_arr[i]),
            .ovf   (ovf_vec[i])
        );
    end

    // Capture the pre-edge counter value; hold otherwise so stalls see a stable operand.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_cnt_q <= '0;
        end else if (bus.rd_en) begin
            if (32'(sel) < NUM_CNT) begin
                perf_cnt_q <= cnt_arr[sel];
            end else begin
                perf_cnt_q <= '0;
            end
        end
    end

    assign bus.perf_cnt = perf_cnt_q;
    assign bus.perf_ovf = ovf_vec;

endmodule

// File: tb/tb_perf_counter_unit.sv
// tb/tb_perf_counter_unit.sv - directed self-checking bench for perf_counter_unit
module tb_perf_counter_unit;
    import perf_pkg::*;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;
    logic [CNT_W-1:0] rd_val;

    perf_counter_unit_if bus ();

    perf_counter_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.evt    = '0;
        bus.rd_en  = 1'b0;
        bus.rd_sel = '0;
        bus.cfg_we = 1'b0;
        bus.cfg_en = '0;
        bus.clr    = '0;
    endtask

    // One capture edge with no other activity; returns perf_cnt after the edge.
    task automatic read_cnt(input int sel, output logic [CNT_W-1:0] val);
        idle_inputs();
        bus.rd_en  = 1'b1;
        bus.rd_sel = SEL_W'(sel);
        tick();
        bus.rd_en  = 1'b0;
        val = bus.perf_cnt;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        idle_inputs();
        rst_n = 1'b0;
        tick();
        chk("reset_perf_cnt", 32'(bus.perf_cnt), 32'h0);
        chk("reset_perf_ovf", 32'(bus.perf_ovf), 32'h0);
        rst_n = 1'b1;

        // 1: idle read
        read_cnt(CNT_INSTR, rd_val);
        chk("idle_read_sel1", 32'(rd_val), 32'h0);

        // 2: ten cycle events, read, then hold across non-read cycles
        bus.evt = 4'b0001;
        for (int i = 0; i < 10; i++) tick();
        read_cnt(CNT_CYCLE, rd_val);
        chk("cycle_cnt_10", 32'(rd_val), 32'h000A);
        bus.evt = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold_perf_cnt", 32'(bus.perf_cnt), 32'h000A);
        end
        // counters now: c0=15, c1=5, c2=5, c3=5

        // 4: read + clear + event on counter 1 in one edge
        idle_inputs();
        bus.clr    = 4'b0010;
        bus.evt    = 4'b0010;
        bus.rd_en  = 1'b1;
        bus.rd_sel = SEL_W'(CNT_INSTR);
        tick();
        chk("rd_clr_pre_value", 32'(bus.perf_cnt), 32'h0005);
        chk("rd_clr_ovf", 32'(bus.perf_ovf), 32'h0);
        read_cnt(CNT_INSTR, rd_val);
        chk("clr_counter1_zero", 32'(rd_val), 32'h0);

        // 3: counter 2 to 0xFFFE then two more events
        idle_inputs();
        bus.clr = 4'b0100;
        tick();
        idle_inputs();
        bus.evt = 4'b0100;
        for (int i = 0; i < 32'hFFFE; i++) tick();
        read_cnt(CNT_STALL, rd_val);
        chk("stall_cnt_fffe", 32'(rd_val), 32'hFFFE);
        bus.evt = 4'b0100;
        tick();
        chk("ovf_before_wrap", 32'(bus.perf_ovf), 32'h0);
        tick();
        chk("ovf_after_max_inc", 32'(bus.perf_ovf), 32'h4);
        read_cnt(CNT_STALL, rd_val);
`ifdef PERF_CNT_SAT_EN
        chk("stall_cnt_at_max", 32'(rd_val), 32'hFFFF);
`else
        chk("stall_cnt_wrapped", 32'(rd_val), 32'h0000);
`endif
        bus.evt = 4'b0100;
        tick();
        read_cnt(CNT_STALL, rd_val);
`ifdef PERF_CNT_SAT_EN
        chk("stall_cnt_stays_max", 32'(rd_val), 32'hFFFF);
`else
        chk("stall_cnt_after_wrap", 32'(rd_val), 32'h0001);
`endif
        chk("ovf_sticky", 32'(bus.perf_ovf), 32'h4);

        // 5: mask write on the same edge as an event uses the old mask
        idle_inputs();
        bus.cfg_we = 1'b1;
        bus.cfg_en = 4'b1101;
        bus.evt    = 4'b0010;
        tick();
        idle_inputs();
        bus.evt = 4'b0010;
        tick();
        read_cnt(CNT_INSTR, rd_val);
        chk("masked_counter1", 32'(rd_val), 32'h0001);
        bus.evt = 4'b0001;
        tick();
        read_cnt(CNT_CYCLE, rd_val);
        chk("enabled_counter0", 32'(rd_val), 32'h0010);

        // 6: reset overrides read, events and config on the same edge
        idle_inputs();
        rst_n      = 1'b0;
        bus.rd_en  = 1'b1;
        bus.rd_sel = SEL_W'(CNT_CYCLE);
        bus.evt    = 4'b1111;
        bus.cfg_we = 1'b1;
        bus.cfg_en = 4'b0000;
        tick();
        chk("rst_perf_cnt", 32'(bus.perf_cnt), 32'h0);
        chk("rst_perf_ovf", 32'(bus.perf_ovf), 32'h0);
        rst_n = 1'b1;
        idle_inputs();
        bus.evt = 4'b0010;
        tick();
        read_cnt(CNT_INSTR, rd_val);
        chk("rst_en_all_ones", 32'(rd_val), 32'h0001);
        read_cnt(CNT_CYCLE, rd_val);
        chk("rst_counter0_zero", 32'(rd_val), 32'h0);
        read_cnt(CNT_BRTAKEN, rd_val);
        chk("rst_counter3_zero", 32'(rd_val), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
